// File: rtl/loader_pkg.sv
// Shared types and sizing for the boot-time instruction loader.
package loader_pkg;
  localparam int LEN_W          = 16;
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_W         = 8;
  localparam int WORD_W         = BYTE_W * BYTES_PER_WORD;
  localparam int CNT_W          = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_t;
endpackage

// File: rtl/instr_loader_if.sv
// Byte stream in, instruction-memory write port and core status out.
interface instr_loader_if;
  import loader_pkg::*;

  logic [BYTE_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              reload;
  logic              im_we;
  logic [WORD_W-1:0] im_addr;
  logic [WORD_W-1:0] im_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              err;

  modport master (
    output in_data, in_valid, reload,
    input  in_ready, im_we, im_addr, im_wdata, cpu_hold, load_done, err
  );

  modport slave (
    input  in_data, in_valid, reload,
    output in_ready, im_we, im_addr, im_wdata, cpu_hold, load_done, err
  );
endinterface

// File: rtl/instr_loader_byte_packer.sv
// Big-endian byte-to-word shifter with a byte counter; the first byte ends up in [31:24].
module byte_packer
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [BYTE_W-1:0] din,
  output logic [WORD_W-1:0] word_next,
  output logic              word_full
);

  // Only the three older bytes are stored; the completed word is taken from word_next
  // on the fourth shift, so the top byte never needs to be held.
  logic [WORD_W-BYTE_W-1:0] word;
  logic [CNT_W-1:0]         byte_cnt;

  assign word_next = {word, din};
  assign word_full = (byte_cnt == CNT_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      byte_cnt <= '0;
    end else if (shift_en) begin
      byte_cnt <= byte_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (shift_en) begin
      word <= word_next[WORD_W-BYTE_W-1:0];
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Length-prefixed boot loader: packs a byte stream into words and writes them to instruction memory.
module instr_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input logic           clk,
  input logic           rst,
  instr_loader_if.slave bus
);

  state_t            state;
  state_t            state_next;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  len_full;
  logic [LEN_W-1:0]  word_cnt;
  logic [LEN_W-1:0]  word_cnt_inc;
  logic [WORD_W-1:0] addr;
  logic [WORD_W-1:0] wdata;
  logic [WORD_W-1:0] word_next;
  logic              word_full;
  logic              shift_en;
  logic              clear;
  logic              hs;
  logic              len_too_big;

  assign hs           = bus.in_valid && bus.in_ready;
  assign len_full     = {len[LEN_W-1:BYTE_W], bus.in_data};
  assign len_too_big  = 32'(len_full) > MAX_WORDS;
  assign word_cnt_inc = word_cnt + LEN_W'(1);

  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .shift_en  (shift_en),
    .din       (bus.in_data),
    .word_next (word_next),
    .word_full (word_full)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= LEN_HI;
    end else begin
      state <= state_next;
    end
  end

  // reload takes priority over any handshake in the same cycle, so that byte is dropped
  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    clear      = 1'b0;
    if (bus.reload) begin
      state_next = LEN_HI;
      clear      = 1'b1;
    end else begin
      case (state)
        LEN_HI: if (hs) state_next = LEN_LO;
        LEN_LO: begin
          if (hs) begin
            if (len_full == '0) begin
              state_next = DONE;
            end else if (len_too_big) begin
              state_next = ERR;
            end else begin
              state_next = DATA;
              clear      = 1'b1;
            end
          end
        end
        DATA: begin
          if (hs) begin
            shift_en = 1'b1;
            if (word_full) state_next = WRITE;
          end
        end
        WRITE:   state_next = (word_cnt_inc == len) ? DONE : DATA;
        DONE:    state_next = DONE;
        ERR:     state_next = ERR;
        default: state_next = LEN_HI;
      endcase
    end
  end

  // addr tracks BASE_ADDR + 4*word_cnt incrementally; wdata is captured as the word completes
  always_ff @(posedge clk) begin
    if (!rst) begin
      len      <= '0;
      word_cnt <= '0;
      addr     <= BASE_ADDR;
      wdata    <= '0;
    end else if (bus.reload) begin
      len      <= '0;
      word_cnt <= '0;
      addr     <= BASE_ADDR;
    end else begin
      case (state)
        LEN_HI: if (hs) len[LEN_W-1:BYTE_W] <= bus.in_data;
        LEN_LO: begin
          if (hs) begin
            len      <= len_full;
            word_cnt <= '0;
            addr     <= BASE_ADDR;
          end
        end
        DATA:   if (hs && word_full) wdata <= word_next;
        WRITE: begin
          word_cnt <= word_cnt_inc;
          addr     <= addr + 32'd4;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = rst && ((state == LEN_HI) || (state == LEN_LO) || (state == DATA));
  assign bus.im_we     = (state == WRITE);
  assign bus.im_addr   = addr;
  assign bus.im_wdata  = wdata;
  assign bus.cpu_hold  = (state != DONE);
  assign bus.load_done = (state == DONE);
  assign bus.err       = (state == ERR);

endmodule

// File: doc/instr_loader.md
# instr_loader

Boot-time program loader: the write side of the instruction memory that the single-cycle core only reads. It accepts a length-prefixed byte stream over a valid/ready handshake and packs bytes big-endian into 32-bit words. Each word is written into instruction memory at consecutive word addresses from `BASE_ADDR`. The core is held in reset until the whole image is written.

## Interface
- `BASE_ADDR`, default `32'h0000_0000`: byte address of the first written word; must be word aligned.
- `MAX_WORDS`, default `1024`: largest accepted image length in words; a larger header is an error.
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: reset, synchronous, active-low.
- `in_data` input, 8 bits: stream byte.
- `in_valid` input, 1 bit: `in_data` is valid.
- `in_ready` output, 1 bit: loader accepts a byte this cycle; a byte transfers when `in_valid && in_ready`.
- `reload` input, 1 bit: single-cycle pulse that restarts loading.
- `im_we` output, 1 bit: instruction memory write strobe, one cycle per word.
- `im_addr` output, 32 bits: write byte address, always word aligned.
- `im_wdata` output, 32 bits: write word.
- `cpu_hold` output, 1 bit: high keeps the core (PC) in reset.
- `load_done` output, 1 bit: image completely written.
- `err` output, 1 bit: header length exceeded `MAX_WORDS`.

## Operation
- **FSM states:** `LEN_HI`, `LEN_LO`, `DATA`, `WRITE`, `DONE`, `ERR`. Reset enters `LEN_HI`.
- **`LEN_HI`:** `in_ready`=1. A handshake captures `len[15:8]` and moves to `LEN_LO`.
- **`LEN_LO`:** `in_ready`=1. A handshake captures `len[7:0]`, then:
  - `len`==0 goes to `DONE`.
  - `len`>`MAX_WORDS` goes to `ERR`.
  - Otherwise go to `DATA` with `byte_cnt`=0 and `word_cnt`=0.
- **`DATA`:** `in_ready`=1. Each handshake shifts the byte in as `word={word[23:0],in_data}`, so the first byte lands in [31:24]. `byte_cnt`++, 2-bit.
  - The handshake with `byte_cnt`==3 moves to `WRITE`.
- **`WRITE`:** `in_ready`=0 and `im_we`=1 for exactly one cycle.
  - `im_addr`=`BASE_ADDR`+4*`word_cnt` (32-bit arithmetic, wraps modulo 2^32).
  - `im_wdata`=assembled word.
  - Then `word_cnt`++. If the new `word_cnt`==`len`, go to `DONE`; otherwise go to `DATA`.
- **`DONE`:** `in_ready`=0, `cpu_hold`=0, `load_done`=1. Extra stream bytes are not accepted (they stall).
- **`ERR`:** `in_ready`=0, `cpu_hold`=1, `err`=1.
- **`reload`:** in any state, goes to `LEN_HI` next cycle with `cpu_hold`=1, `load_done`=0, `err`=0 and counters cleared.
  - `reload` wins over a simultaneous handshake; that byte is dropped.
  - A partial word is discarded. Words already written stay in memory.
- `in_valid` may drop between bytes. The FSM simply waits; there is no timeout.

## Timing
- **Reset values:**
  - `in_ready`=0 while `rst`=0 (gated); 1 the first cycle after release.
  - `im_we`=0, `im_addr`=`BASE_ADDR`, `im_wdata`=0.
  - `cpu_hold`=1, `load_done`=0, `err`=0.
- **Output sources:**
  - `im_addr` and `im_wdata` are registered and are stable in the `WRITE` cycle.
  - `im_we`, `in_ready`, `cpu_hold`, `load_done` and `err` decode from the state register only; no input-to-output combinational path.
- **Latency:**
  - The fourth byte of a word accepted at edge t gives `im_we`=1 during cycle t+1.
  - Throughput is 4 bytes per 5 cycles.
  - The last `WRITE` at cycle t gives `cpu_hold`=0 and `load_done`=1 from cycle t+1.
- **Reset mid-operation:** `rst` low at any edge overrides everything, including `reload`, and returns all outputs to reset values on that edge.

## Structure
- Shared package `loader_pkg`:
  - state enum
  - `LEN_W`=16
  - `BYTES_PER_WORD`=4
- Natural sub-module: `byte_packer`. It holds the 32-bit shift register plus the 2-bit `byte_cnt`, with `shift_en`, `clear` and `word_full` ports.
- The FSM, word counter, address generation and `MAX_WORDS` check stay in `instr_loader`.

## Test plan
- **Basic load:** stream `00 02 20 08 00 05 00 09 40 20`, then:
  - `im_we` pulses twice: addr 0 / data `20080005`, then addr 4 / data `00094020`.
  - `cpu_hold` falls the cycle after the second write; `load_done`=1.
- **Zero length:** header `00 00` → `DONE` after the second byte; no `im_we`; `cpu_hold`=0.
- **Overlength:** `MAX_WORDS`=1024 with header `04 01` → `err`=1, `cpu_hold` stays 1, `in_ready`=0. A `reload` pulse clears `err` and `in_ready`=1 the next cycle.
- **Stalls and base address:** `BASE_ADDR`=`32'h100`, `in_valid` toggled randomly over a 3-word image → writes to `0x100`, `0x104`, `0x108` with correct data; `in_ready`=0 in every `WRITE` cycle.
- **Reload mid-word:** after 2 data bytes, `reload` asserted together with a valid byte → byte dropped; the next two bytes are taken as the new length header. `rst`=0 mid-load → every output at its reset value at the next edge.
